stream_buf: RTL and testbench

STREAM_BUF -- requirements
Module: stream_buf

---
 rtl/stream_buf_pkg.sv | 18 +
 rtl/stream_buf_mem.sv | 45 ++++
 rtl/stream_buf.sv | 145 ++++++++++++++
 tb/tb_stream_buf.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_buf_pkg.sv
// Shared types and defaults for the stream_buf sample FIFO.
// Optional checksum feature is enabled by STREAM_BUF_CHKSUM_EN.
package stream_buf_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int DEPTH_DEF = 8;
    localparam int LVL_W     = $clog2(DEPTH_DEF) + 1;

    typedef logic [LVL_W-1:0]     level_t;
    typedef logic [WIDTH_DEF-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_e;

endpackage

// File: rtl/stream_buf_mem.sv
// DEPTH x WIDTH register array, one write port, one registered read port.
// A same-cycle write to the read address is forwarded to the read register.
module stream_buf_mem
    import stream_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_d = mem_q[raddr_i];
        if (we_i && (waddr_i == raddr_i)) begin
            rdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stream_buf.sv
// Sample FIFO with drop counter and optional running checksum.
// Checksum register is built only when STREAM_BUF_CHKSUM_EN is defined.
module stream_buf
    import stream_buf_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_vld,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [WIDTH-1:0]       out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic [7:0]             drop_cnt,
    input  logic                   sum_clr,
    output logic [WIDTH-1:0]       chksum
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [7:0]      drop_q, drop_d;
    logic            full;
    logic            pop;
    logic            wr;
    logic            drop;

    assign out_vld  = (state_q != ST_EMPTY);
    assign level    = level_q;
    assign drop_cnt = drop_q;

    always_comb begin
        full = (state_q == ST_FULL);
        pop  = out_vld && out_rdy;
        wr   = in_vld && (!full || pop);
        drop = in_vld && full && !pop;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop_d   = drop_q;
        if (wr) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({wr, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (drop && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (wr) state_d = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (pop && !wr && level_q == LW'(1)) begin
                    state_d = ST_EMPTY;
                end else if (wr && !pop
                             && level_q == LW'(DEPTH - 1)) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (pop && !wr) state_d = ST_PARTIAL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_EMPTY;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    // Read address looks one pop ahead so the head is ready next cycle.
    stream_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (wr),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_d),
        .rdata_o (out_data)
    );

`ifdef STREAM_BUF_CHKSUM_EN
    logic [WIDTH-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (sum_clr) begin
            sum_d = wr ? in_data : '0;
        end else if (wr) begin
            sum_d = sum_q + in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign chksum = sum_q;
`else
    logic unused_sum_clr;
    assign unused_sum_clr = sum_clr;
    assign chksum = '0;
`endif

endmodule

// File: tb/tb_stream_buf.sv
// Directed vector bench for stream_buf.
// Table rows cover pass-through, overflow and full write+pop.
module tb_stream_buf;
    import stream_buf_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_vld;
    logic [7:0] in_data;
    logic       out_vld;
    logic       out_rdy;
    logic [7:0] out_data;
    logic [3:0] level;
    logic [7:0] drop_cnt;
    logic       sum_clr;
    logic [7:0] chksum;

    int checks;
    int errors;

    typedef struct {
        logic       vld;
        logic [7:0] din;
        logic       rdy;
        logic       e_vld;
        logic       c_dat;
        logic [7:0] e_dat;
        logic [3:0] e_lvl;
        logic [7:0] e_drop;
    } vec_t;

    vec_t tbl[$];

    stream_buf #(
        .WIDTH (8),
        .DEPTH (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .level    (level),
        .drop_cnt (drop_cnt),
        .sum_clr  (sum_clr),
        .chksum   (chksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d,
                        input logic r);
        in_vld  = v;
        in_data = d;
        out_rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        sum_clr = 1'b0;
        rst     = 1'b1;
        #3;
        rst     = 1'b0;
    endtask

    function automatic void add(logic v, logic [7:0] d, logic r,
                                logic ev, logic cd, logic [7:0] ed,
                                logic [3:0] el, logic [7:0] edr);
        vec_t t;
        t.vld = v;   t.din = d;   t.rdy = r;
        t.e_vld = ev; t.c_dat = cd; t.e_dat = ed;
        t.e_lvl = el; t.e_drop = edr;
        tbl.push_back(t);
    endfunction

    logic       en;
    logic [7:0] tmp;
    logic       r;
    logic       wv;
    logic       pp;
    int         sz;
    sample_t    mq[$];
    logic [7:0] got[$];
    logic [7:0] pass_seq[8];

    initial begin
        checks = 0;
        errors = 0;
`ifdef STREAM_BUF_CHKSUM_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        in_vld  = 1'b0;
        in_data = '0;
        out_rdy = 1'b0;
        sum_clr = 1'b0;
        rst     = 1'b1;
        #12;
        check("rst out_vld", 32'(out_vld), 0);
        check("rst level", 32'(level), 0);
        check("rst drop", 32'(drop_cnt), 0);
        check("rst out_data", 32'(out_data), 0);
        check("rst chksum", 32'(chksum), 0);
        rst = 1'b0;

        // Pass-through: each sample is head one cycle after write
        pass_seq = '{8'd1, 8'd1, 8'd2, 8'd3,
                     8'd5, 8'd8, 8'd13, 8'd21};
        for (int k = 0; k < 8; k++)
            add(1, pass_seq[k], 1, 1, 1, pass_seq[k], 1, 0);
        add(0, 0, 1, 0, 0, 0, 0, 0);
        // Overflow: ten pushes into eight entries
        for (int k = 1; k <= 10; k++)
            add(1, 8'(k), 0, 1, 1, 8'd1,
                4'(k < 8 ? k : 8), 8'(k > 8 ? k - 8 : 0));
        for (int j = 1; j <= 8; j++)
            add(0, 0, 1, j < 8, j < 8, 8'(j + 1), 4'(8 - j), 2);
        // Refill, then write+pop while full, then drop on full
        for (int k = 0; k < 8; k++)
            add(1, 8'(8'h40 + k), 0, 1, 1, 8'h40, 4'(k + 1), 2);
        add(1, 8'h48, 1, 1, 1, 8'h41, 8, 2);
        add(1, 8'h49, 0, 1, 1, 8'h41, 8, 3);
        for (int j = 1; j <= 8; j++)
            add(0, 0, 1, j < 8, j < 8, 8'(8'h41 + j), 4'(8 - j), 3);

        foreach (tbl[i]) begin
            step(tbl[i].vld, tbl[i].din, tbl[i].rdy);
            check($sformatf("row%0d vld", i),
                  32'(out_vld), 32'(tbl[i].e_vld));
            check($sformatf("row%0d lvl", i),
                  32'(level), 32'(tbl[i].e_lvl));
            check($sformatf("row%0d drop", i),
                  32'(drop_cnt), 32'(tbl[i].e_drop));
            if (tbl[i].c_dat)
                check($sformatf("row%0d data", i),
                      32'(out_data), 32'(tbl[i].e_dat));
        end

        // Drop counter saturation
        for (int i = 1; i <= 268; i++) begin
            step(1, 8'h77, 0);
            if (i == 259) check("drop 254", 32'(drop_cnt), 254);
        end
        check("drop sat", 32'(drop_cnt), 255);
        check("sat level", 32'(level), 8);
        check("sat data", 32'(out_data), 8'h77);

        // Reset mid-stream with five entries buffered
        for (int j = 0; j < 8; j++) step(0, 0, 1);
        check("drained", 32'(level), 0);
        for (int j = 0; j < 5; j++) step(1, 8'(8'h11 + j), 0);
        check("pre-rst lvl", 32'(level), 5);
        check("pre-rst data", 32'(out_data), 8'h11);
        #2 rst = 1'b1;
        #1;
        check("mid-rst vld", 32'(out_vld), 0);
        check("mid-rst lvl", 32'(level), 0);
        check("mid-rst drop", 32'(drop_cnt), 0);
        #2 rst = 1'b0;
        step(1, 8'h2A, 0);
        check("post-rst vld", 32'(out_vld), 1);
        check("post-rst data", 32'(out_data), 8'h2A);
        check("post-rst lvl", 32'(level), 1);

        // Backpressure: ready toggles while 16 samples stream in
        do_reset();
        for (int k = 0; k < 56; k++) begin
            r  = (k % 2) == 1;
            wv = k < 16;
            pp = (mq.size() > 0) && r;
            if (out_vld && r) got.push_back(out_data);
            sz = mq.size();
            if (pp) tmp = mq.pop_front();
            if (wv && (sz < 8 || pp)) mq.push_back(8'(k));
            step(wv, 8'(k), r);
            check($sformatf("bp%0d vld", k),
                  32'(out_vld), 32'(mq.size() > 0));
            check($sformatf("bp%0d lvl", k),
                  32'(level), 32'(mq.size()));
            if (mq.size() > 0)
                check($sformatf("bp%0d data", k),
                      32'(out_data), 32'(mq[0]));
        end
        check("bp count", 32'(got.size()), 16);
        foreach (got[i])
            check($sformatf("bp order%0d", i), 32'(got[i]), 32'(i));
        check("bp drop", 32'(drop_cnt), 0);

        // Checksum: wraps mod 256, clear with concurrent write
        do_reset();
        step(1, 8'h90, 0);
        check("sum 90", 32'(chksum), en ? 32'h90 : 0);
        step(1, 8'h80, 0);
        check("sum wrap", 32'(chksum), en ? 32'h10 : 0);
        sum_clr = 1'b1;
        step(1, 8'h05, 0);
        check("sum clr+wr", 32'(chksum), en ? 32'h05 : 0);
        step(0, 0, 0);
        check("sum clr", 32'(chksum), 0);
        sum_clr = 1'b0;
        check("sum lvl", 32'(level), 3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
